// File: rtl/ksa_shuffle_fsm.sv
// RC4 key-scheduling shuffle stage: for i = 0..255, j += S[i] + key[i mod KEY_BYTES], swap S[i]/S[j].
// Drives the shuffle-side working-RAM request ports; all outputs registered from the next state.
// Optional feature macro: SHUFFLE_SAME_IDX_SKIP_EN (skip both writes when i == j).
module ksa_shuffle_fsm #(
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    output logic [1:0]             mem_sel,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int unsigned WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_SI   = 4'd1,
        WAIT_SI = 4'd2,
        RD_SJ   = 4'd3,
        WAIT_SJ = 4'd4,
        WR_SI   = 4'd5,
        WR_SJ   = 4'd6,
        NEXT    = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [7:0]    si_q, si_d;
    logic [7:0]    sj_q, sj_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [7:0]    address_d, data_d;
    logic          wren_d, busy_d, done_d;
    logic [1:0]    mem_sel_d;
    logic [7:0]    key_byte;
    logic          wait_last;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        kidx_d    = kidx_q;
        wcnt_d    = wcnt_q;
        address_d = 8'd0;
        data_d    = 8'd0;
        wren_d    = 1'b0;
        mem_sel_d = 2'b00;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        key_byte  = 8'd0;
        wait_last = (wcnt_q == WW'(READ_LAT - 1));

        // Key byte 0 is the most significant byte of secret_key
        for (int unsigned k = 0; k < KEY_BYTES; k++) begin
            if (kidx_q == KW'(k)) begin
                key_byte = secret_key[8*(KEY_BYTES-k)-1 -: 8];
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_SI;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    kidx_d  = '0;
                end
            end
            RD_SI: begin
                state_d = WAIT_SI;
                wcnt_d  = '0;
            end
            WAIT_SI: begin
                if (wait_last) begin
                    si_d    = q;
                    j_d     = j_q + q + key_byte;
                    state_d = RD_SJ;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            RD_SJ: begin
                state_d = WAIT_SJ;
                wcnt_d  = '0;
            end
            WAIT_SJ: begin
                if (wait_last) begin
                    sj_d = q;
`ifdef SHUFFLE_SAME_IDX_SKIP_EN
                    state_d = (i_q == j_q) ? NEXT : WR_SI;
`else
                    state_d = WR_SI;
`endif
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            WR_SI: state_d = WR_SJ;
            WR_SJ: state_d = NEXT;
            NEXT: begin
                if (i_q == 8'hFF) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + KW'(1);
                    state_d = RD_SI;
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the state being entered so they are valid throughout it
        case (state_d)
            RD_SI, WAIT_SI, NEXT: begin
                address_d = i_d;
                mem_sel_d = 2'b01;
                busy_d    = 1'b1;
            end
            RD_SJ, WAIT_SJ: begin
                address_d = j_d;
                mem_sel_d = 2'b01;
                busy_d    = 1'b1;
            end
            WR_SI: begin
                address_d = i_d;
                data_d    = sj_d;
                wren_d    = 1'b1;
                mem_sel_d = 2'b01;
                busy_d    = 1'b1;
            end
            WR_SJ: begin
                address_d = j_d;
                data_d    = si_d;
                wren_d    = 1'b1;
                mem_sel_d = 2'b01;
                busy_d    = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            kidx_q  <= '0;
            wcnt_q  <= '0;
            address <= 8'd0;
            data    <= 8'd0;
            wren    <= 1'b0;
            mem_sel <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            wcnt_q  <= wcnt_d;
            address <= address_d;
            data    <= data_d;
            wren    <= wren_d;
            mem_sel <= mem_sel_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Bench for ksa_shuffle_fsm: working-RAM model (registered address, unregistered q), write-event
// vectors, cycle timing, DONE/IDLE handshake, mid-run async reset and a reference RC4 KSA model.
module tb_ksa_shuffle_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic [1:0]  mem_sel;
    logic        busy;
    logic        done;

    logic        preload;
    logic [7:0]  mem [256];
    logic [7:0]  addr_r;
    logic [7:0]  exp_s [256];
    logic [15:0] wq [$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] key;
        int          iter;
        logic [31:0] exp_writes;   // {addr0, data0, addr1, data1}
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    ksa_shuffle_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .mem_sel    (mem_sel),
        .busy       (busy),
        .done       (done)
    );

    // Working RAM: inputs registered on the rising edge, read data combinational from the held address
    always @(posedge clk) begin
        if (preload) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        end else if (wren) begin
            mem[address] <= data;
        end
        addr_r <= address;
    end
    assign q = mem[addr_r];

    // Record every write request
    always @(negedge clk) begin
        if (wren) wq.push_back({address, data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference RC4 key schedule starting from the identity permutation
    task automatic build_model(input logic [23:0] key);
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb;
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            kb       = 8'(key >> (8 * (2 - (n % 3))));
            j        = j + exp_s[n] + kb;
            t        = exp_s[n];
            exp_s[n] = exp_s[j];
            exp_s[j] = t;
        end
    endtask

    task automatic check_vectors(input logic [23:0] key);
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].key == key) begin
                if (wq.size() >= 2 * vecs[v].iter + 2) begin
                    check($sformatf("writes_key%h_i%0d", key, vecs[v].iter),
                          {wq[2*vecs[v].iter], wq[2*vecs[v].iter+1]}, vecs[v].exp_writes);
                end else begin
                    check($sformatf("writes_present_key%h_i%0d", key, vecs[v].iter),
                          32'(wq.size()), 32'(2 * vecs[v].iter + 2));
                end
            end
        end
    endtask

    // One complete run; pulse drops start shortly after it is accepted
    task automatic run(input logic [23:0] key, input bit pulse);
        int n;
        int busy_cnt;
        int bad;
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        wq.delete();
        secret_key = key;
        start      = 1'b1;
        n          = 0;
        busy_cnt   = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (n == 1) check("first_cycle_rd", {22'd0, busy, mem_sel, wren, address}, {22'd0, 1'b1, 2'b01, 1'b0, 8'd0});
            if (pulse && n == 3) start = 1'b0;
        end
        check($sformatf("done_cycle_key%h", key), 32'(n), 32'd1793);
        check($sformatf("busy_cycles_key%h", key), 32'(busy_cnt), 32'd1792);
        check($sformatf("write_count_key%h", key), 32'(wq.size()), 32'd512);
        build_model(key);
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== exp_s[a]) bad++;
        check($sformatf("final_ram_mismatches_key%h", key), 32'(bad), 32'd0);
        if (!pulse) begin
            repeat (3) @(negedge clk);
            check("done_held_no_rerun", {27'd0, done, busy, wren, mem_sel}, {27'd0, 1'b1, 1'b0, 1'b0, 2'b00});
            start = 1'b0;
        end
        @(negedge clk);
        check("idle_after_start_low", {12'd0, address, data, wren, mem_sel, busy, done},
              32'd0);
    endtask

    initial begin
        vecs[0] = '{24'h000000, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[1] = '{24'h000000, 1, {8'h01, 8'h01, 8'h01, 8'h01}};
        vecs[2] = '{24'h000000, 2, {8'h02, 8'h03, 8'h03, 8'h02}};
        vecs[3] = '{24'h000000, 3, {8'h03, 8'h05, 8'h05, 8'h02}};
        vecs[4] = '{24'h000249, 1, {8'h01, 8'h03, 8'h03, 8'h01}};
        vecs[5] = '{24'h000249, 2, {8'h02, 8'h4E, 8'h4E, 8'h02}};
        vecs[6] = '{24'hFFFFFF, 0, {8'h00, 8'hFF, 8'hFF, 8'h00}};
        vecs[7] = '{24'hFFFFFF, 1, {8'h01, 8'h00, 8'hFF, 8'h01}};

        rst_n      = 1'b1;
        start      = 1'b0;
        preload    = 1'b0;
        secret_key = 24'd0;
        #1 rst_n = 1'b0;
        #11;
        check("reset_outputs", {12'd0, address, data, wren, mem_sel, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", {12'd0, address, data, wren, mem_sel, busy, done}, 32'd0);

        // Table-driven runs over the key set
        begin
            logic [23:0] keys [3];
            keys[0] = 24'h000000;
            keys[1] = 24'h000249;
            keys[2] = 24'hFFFFFF;
            for (int k = 0; k < 3; k++) begin
                run(keys[k], 1'b0);
                check_vectors(keys[k]);
            end
        end

        // Async reset during WR_SI of i = 100
        begin
            int n;
            @(negedge clk);
            preload = 1'b1;
            @(negedge clk);
            preload    = 1'b0;
            secret_key = 24'h000000;
            start      = 1'b1;
            n          = 0;
            while (n < 705) begin
                @(negedge clk);
                n++;
            end
            check("wr_si_i100", {20'd0, wren, mem_sel, busy, address}, {20'd0, 1'b1, 2'b01, 1'b1, 8'd100});
            #2 rst_n = 1'b0;
            #1;
            check("async_reset_outputs", {12'd0, address, data, wren, mem_sel, busy, done}, 32'd0);
            start = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("idle_after_reset", {12'd0, address, data, wren, mem_sel, busy, done}, 32'd0);
        end

        // Fresh run from i = 0 with start dropped while busy
        run(24'h000000, 1'b1);
        check_vectors(24'h000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
